in_unit_reader: RTL and testbench

- Input-side counterpart of the calculator's display path. Accepts signed decimal operand entry from a keypad/switch front panel: up to 3 BCD digits plus a sign key.
- Debounces the keys, accumulates the magnitude, range-checks it and converts it to an 8-bit two's-complement operand.
- Presents the operand to the datapath with a valid/ack handshake.
- Exports live entry state so the display can echo the number as it is typed.

---
 rtl/in_unit_reader_if.sv | 12 +
 rtl/in_unit_reader.sv | 195 +++++++++++++++++++
 tb/tb_in_unit_reader.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/in_unit_reader_if.sv
// Operand handshake bundle between the front-panel entry unit and the datapath.
// The entry unit (master) drives the operand, its valid flag and the range error;
// the datapath (slave) returns the acknowledge level.
interface in_unit_reader_if;
  logic [7:0] the_output;
  logic       out_valid;
  logic       err;
  logic       out_ack;

  modport master (output the_output, output out_valid, output err, input out_ack);
  modport slave  (input the_output, input out_valid, input err, output out_ack);
endinterface

// File: rtl/in_unit_reader.sv
// Front-panel operand entry: debounces four keys, accumulates up to three BCD
// digits plus a sign, range-checks the magnitude and hands an 8-bit two's
// complement operand to the datapath over a valid/ack handshake.
module in_unit_reader #(
  parameter int DEB_CYCLES = 100000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [3:0]         digit_in,
  input  logic               digit_key,
  input  logic               neg_key,
  input  logic               enter_key,
  input  logic               clear_key,
  output logic [9:0]         entry_mag,
  output logic               entry_neg,
  output logic [1:0]         digit_cnt,
  in_unit_reader_if.master   bus
);

  localparam int CW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);

  // Key bit order: 0 digit, 1 neg, 2 enter, 3 clear.
  localparam int K_DIG = 0;
  localparam int K_NEG = 1;
  localparam int K_ENT = 2;
  localparam int K_CLR = 3;

  typedef enum logic [1:0] {S_IDLE, S_ENTRY, S_DONE, S_ERR} state_t;

  logic [3:0]    w_keys;
  logic [3:0]    r_s1, r_s2, r_acc;
  logic [CW-1:0] r_dcnt [4];
  logic [3:0]    r_dig_s1, r_dig_s2;
  logic [3:0]    w_press;

  state_t        r_state, w_state_nxt;
  logic [9:0]    r_mag, w_mag_nxt;
  logic          r_neg, w_neg_nxt;
  logic [1:0]    r_cnt, w_cnt_nxt;
  logic [7:0]    r_out, w_out_nxt;
  logic          r_valid, w_valid_nxt;
  logic          r_err, w_err_nxt;

  logic          w_clr, w_ent, w_tgl, w_dig, w_dig_ok, w_in_range;
  logic [9:0]    w_mac;
  logic [7:0]    w_neg_out;

  assign w_keys = {clear_key, enter_key, neg_key, digit_key};

  // Synchronize keys and digit switches; debounce each key into an accepted level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s1     <= '0;
      r_s2     <= '0;
      r_acc    <= '0;
      r_dig_s1 <= '0;
      r_dig_s2 <= '0;
      for (int i = 0; i < 4; i++) r_dcnt[i] <= '0;
    end else begin
      r_s1     <= w_keys;
      r_s2     <= r_s1;
      r_dig_s1 <= digit_in;
      r_dig_s2 <= r_dig_s1;
      for (int i = 0; i < 4; i++) begin
        if (r_s2[i] != r_acc[i]) begin
          if (r_dcnt[i] == LAST) begin
            r_acc[i]  <= r_s2[i];
            r_dcnt[i] <= '0;
          end else begin
            r_dcnt[i] <= r_dcnt[i] + CW'(1);
          end
        end else begin
          r_dcnt[i] <= '0;
        end
      end
    end
  end

  // Press pulse fires on the cycle the accepted level is about to rise, so the
  // FSM acts on the same edge the debouncer accepts the press.
  always_comb begin
    w_press = '0;
    for (int i = 0; i < 4; i++)
      w_press[i] = r_s2[i] && !r_acc[i] && (r_dcnt[i] == LAST);
  end

  // Only the highest-priority pulse of a cycle acts: clear > enter > neg > digit.
  assign w_clr = w_press[K_CLR];
  assign w_ent = w_press[K_ENT] && !w_press[K_CLR];
  assign w_tgl = w_press[K_NEG] && !w_press[K_ENT] && !w_press[K_CLR];
  assign w_dig = w_press[K_DIG] && !w_press[K_NEG] && !w_press[K_ENT] && !w_press[K_CLR];

  assign w_dig_ok   = (r_dig_s2 <= 4'd9);
  assign w_mac      = (r_mag << 3) + (r_mag << 1) + {6'd0, r_dig_s2};
  assign w_in_range = r_neg ? (r_mag <= 10'd128) : (r_mag <= 10'd127);
  assign w_neg_out  = 8'd0 - r_mag[7:0];

  // Entry FSM next-state and next register values.
  always_comb begin
    w_state_nxt = r_state;
    w_mag_nxt   = r_mag;
    w_neg_nxt   = r_neg;
    w_cnt_nxt   = r_cnt;
    w_out_nxt   = r_out;
    w_valid_nxt = r_valid;
    w_err_nxt   = r_err;
    case (r_state)
      S_IDLE: begin
        if (w_clr) begin
          w_mag_nxt = '0;
          w_neg_nxt = 1'b0;
          w_cnt_nxt = '0;
        end else if (w_tgl) begin
          w_neg_nxt = !r_neg;
        end else if (w_dig && w_dig_ok) begin
          w_mag_nxt   = {6'd0, r_dig_s2};
          w_cnt_nxt   = 2'd1;
          w_state_nxt = S_ENTRY;
        end
      end
      S_ENTRY: begin
        if (w_clr) begin
          w_mag_nxt   = '0;
          w_neg_nxt   = 1'b0;
          w_cnt_nxt   = '0;
          w_state_nxt = S_IDLE;
        end else if (w_ent) begin
          if (w_in_range) begin
            w_out_nxt   = r_neg ? w_neg_out : r_mag[7:0];
            w_valid_nxt = 1'b1;
            w_err_nxt   = 1'b0;
            w_state_nxt = S_DONE;
          end else begin
            w_err_nxt   = 1'b1;
            w_state_nxt = S_ERR;
          end
        end else if (w_tgl) begin
          w_neg_nxt = !r_neg;
        end else if (w_dig && w_dig_ok && (r_cnt != 2'd3)) begin
          w_mag_nxt = w_mac;
          w_cnt_nxt = r_cnt + 2'd1;
        end
      end
      S_DONE: begin
        if (w_clr || bus.out_ack) begin
          w_valid_nxt = 1'b0;
          w_mag_nxt   = '0;
          w_neg_nxt   = 1'b0;
          w_cnt_nxt   = '0;
          w_state_nxt = S_IDLE;
        end
      end
      S_ERR: begin
        if (w_clr) begin
          w_err_nxt   = 1'b0;
          w_mag_nxt   = '0;
          w_neg_nxt   = 1'b0;
          w_cnt_nxt   = '0;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Entry FSM state and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_mag   <= '0;
      r_neg   <= 1'b0;
      r_cnt   <= '0;
      r_out   <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_mag   <= w_mag_nxt;
      r_neg   <= w_neg_nxt;
      r_cnt   <= w_cnt_nxt;
      r_out   <= w_out_nxt;
      r_valid <= w_valid_nxt;
      r_err   <= w_err_nxt;
    end
  end

  assign entry_mag      = r_mag;
  assign entry_neg      = r_neg;
  assign digit_cnt      = r_cnt;
  assign bus.the_output = r_out;
  assign bus.out_valid  = r_valid;
  assign bus.err        = r_err;

endmodule

// File: tb/tb_in_unit_reader.sv
// Directed bench for in_unit_reader with DEB_CYCLES = 4.
module tb_in_unit_reader;
  localparam int DEB = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] digit_in = 4'd0;
  logic       digit_key = 1'b0, neg_key = 1'b0, enter_key = 1'b0, clear_key = 1'b0;
  logic [9:0] entry_mag;
  logic       entry_neg;
  logic [1:0] digit_cnt;
  int         passed = 0;
  int         total  = 0;

  in_unit_reader_if bus();

  in_unit_reader #(.DEB_CYCLES(DEB)) dut (
    .clk(clk), .reset(reset), .digit_in(digit_in),
    .digit_key(digit_key), .neg_key(neg_key), .enter_key(enter_key), .clear_key(clear_key),
    .entry_mag(entry_mag), .entry_neg(entry_neg), .digit_cnt(digit_cnt),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Mask bits: 0 digit, 1 neg, 2 enter, 3 clear. Holds long enough to debounce
  // press and release, then samples just after a rising edge.
  task automatic press(input logic [3:0] mask, input logic [3:0] d);
    @(negedge clk);
    digit_in = d;
    {clear_key, enter_key, neg_key, digit_key} = mask;
    repeat (8) @(posedge clk);
    @(negedge clk);
    {clear_key, enter_key, neg_key, digit_key} = 4'b0000;
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    bus.out_ack = 1'b0;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if ({bus.the_output, bus.out_valid, bus.err, entry_mag, entry_neg, digit_cnt} !== 23'd0)
      $display("FAIL reset_outputs: got %h, expected 0", {bus.the_output, bus.out_valid, bus.err, entry_mag, entry_neg, digit_cnt});
    else passed++;
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_basic_entry;
    press(4'b0001, 4'd1);
    total++; if ({entry_mag, digit_cnt} !== {10'd1, 2'd1})
      $display("FAIL basic_d1: got mag=%0d cnt=%0d, expected mag=1 cnt=1", entry_mag, digit_cnt); else passed++;
    press(4'b0001, 4'd2);
    total++; if ({entry_mag, digit_cnt} !== {10'd12, 2'd2})
      $display("FAIL basic_d2: got mag=%0d cnt=%0d, expected mag=12 cnt=2", entry_mag, digit_cnt); else passed++;
    press(4'b0001, 4'd7);
    total++; if ({entry_mag, digit_cnt} !== {10'd127, 2'd3})
      $display("FAIL basic_d3: got mag=%0d cnt=%0d, expected mag=127 cnt=3", entry_mag, digit_cnt); else passed++;
    press(4'b0100, 4'd7);
    total++; if ({bus.the_output, bus.out_valid, bus.err} !== {8'h7F, 1'b1, 1'b0})
      $display("FAIL basic_commit: got out=%h v=%b e=%b, expected out=7f v=1 e=0", bus.the_output, bus.out_valid, bus.err); else passed++;
    @(negedge clk); bus.out_ack = 1'b1;
    @(negedge clk); bus.out_ack = 1'b0;
    #1;
    total++; if ({bus.out_valid, digit_cnt} !== 3'b000)
      $display("FAIL basic_ack: got v=%b cnt=%0d, expected v=0 cnt=0", bus.out_valid, digit_cnt); else passed++;
  endtask

  task automatic test_neg_range;
    press(4'b0010, 4'd0);
    total++; if (entry_neg !== 1'b1)
      $display("FAIL neg_toggle: got %b, expected 1", entry_neg); else passed++;
    press(4'b0001, 4'd1); press(4'b0001, 4'd2); press(4'b0001, 4'd8);
    press(4'b0100, 4'd8);
    total++; if ({bus.the_output, bus.out_valid, bus.err} !== {8'h80, 1'b1, 1'b0})
      $display("FAIL neg_128: got out=%h v=%b e=%b, expected out=80 v=1 e=0", bus.the_output, bus.out_valid, bus.err); else passed++;
    @(negedge clk); bus.out_ack = 1'b1;
    @(negedge clk); bus.out_ack = 1'b0;
    press(4'b0001, 4'd1); press(4'b0001, 4'd2); press(4'b0001, 4'd8);
    press(4'b0100, 4'd8);
    total++; if ({bus.err, bus.out_valid, bus.the_output, entry_mag} !== {1'b1, 1'b0, 8'h80, 10'd128})
      $display("FAIL pos_128_err: got e=%b v=%b out=%h mag=%0d, expected e=1 v=0 out=80 mag=128",
               bus.err, bus.out_valid, bus.the_output, entry_mag); else passed++;
    press(4'b0001, 4'd3);
    total++; if ({entry_mag, digit_cnt, bus.err} !== {10'd128, 2'd3, 1'b1})
      $display("FAIL err_freeze: got mag=%0d cnt=%0d e=%b, expected mag=128 cnt=3 e=1", entry_mag, digit_cnt, bus.err); else passed++;
    press(4'b1000, 4'd3);
    total++; if ({bus.err, entry_mag, digit_cnt} !== {1'b0, 10'd0, 2'd0})
      $display("FAIL err_clear: got e=%b mag=%0d cnt=%0d, expected e=0 mag=0 cnt=0", bus.err, entry_mag, digit_cnt); else passed++;
  endtask

  task automatic test_bounce;
    int n;
    bit found;
    @(negedge clk);
    digit_in = 4'd3;
    for (int i = 0; i < 10; i++) begin
      digit_key = (i % 2 == 0);
      repeat (2) @(negedge clk);
    end
    digit_key = 1'b1;
    n = 0;
    found = 1'b0;
    for (int c = 1; c <= 20 && !found; c++) begin
      @(posedge clk); #1;
      if (digit_cnt != 2'd0) begin found = 1'b1; n = c; end
    end
    total++; if (n != DEB + 2)
      $display("FAIL bounce_latency: got %0d cycles (0 = never), expected %0d", n, DEB + 2); else passed++;
    @(negedge clk); digit_key = 1'b0;
    repeat (10) @(posedge clk); #1;
    total++; if ({entry_mag, digit_cnt} !== {10'd3, 2'd1})
      $display("FAIL bounce_single: got mag=%0d cnt=%0d, expected mag=3 cnt=1", entry_mag, digit_cnt); else passed++;
    press(4'b1000, 4'd0);
  endtask

  task automatic test_handshake;
    bus.out_ack = 1'b0;
    press(4'b0001, 4'd5);
    press(4'b0100, 4'd5);
    total++; if ({bus.the_output, bus.out_valid} !== {8'h05, 1'b1})
      $display("FAIL hs_commit: got out=%h v=%b, expected out=05 v=1", bus.the_output, bus.out_valid); else passed++;
    press(4'b0001, 4'd3);
    total++; if ({bus.the_output, bus.out_valid, entry_mag, digit_cnt} !== {8'h05, 1'b1, 10'd5, 2'd1})
      $display("FAIL hs_hold: got out=%h v=%b mag=%0d cnt=%0d, expected out=05 v=1 mag=5 cnt=1",
               bus.the_output, bus.out_valid, entry_mag, digit_cnt); else passed++;
    @(negedge clk); bus.out_ack = 1'b1;
    @(posedge clk); #1;
    total++; if ({bus.out_valid, digit_cnt, entry_mag, bus.the_output} !== {1'b0, 2'd0, 10'd0, 8'h05})
      $display("FAIL hs_ack_edge: got v=%b cnt=%0d mag=%0d out=%h, expected v=0 cnt=0 mag=0 out=05",
               bus.out_valid, digit_cnt, entry_mag, bus.the_output); else passed++;
    press(4'b0001, 4'd2);
    total++; if ({bus.out_valid, entry_mag, digit_cnt} !== {1'b0, 10'd2, 2'd1})
      $display("FAIL hs_stray_ack: got v=%b mag=%0d cnt=%0d, expected v=0 mag=2 cnt=1", bus.out_valid, entry_mag, digit_cnt); else passed++;
    bus.out_ack = 1'b0;
    press(4'b1000, 4'd0);
  endtask

  task automatic test_edge_cases;
    for (int i = 0; i < 4; i++) press(4'b0001, 4'd9);
    total++; if ({entry_mag, digit_cnt} !== {10'd999, 2'd3})
      $display("FAIL edge_4th_digit: got mag=%0d cnt=%0d, expected mag=999 cnt=3", entry_mag, digit_cnt); else passed++;
    press(4'b1000, 4'd0);
    press(4'b0001, 4'hC);
    total++; if ({entry_mag, digit_cnt} !== {10'd0, 2'd0})
      $display("FAIL edge_bad_digit: got mag=%0d cnt=%0d, expected mag=0 cnt=0", entry_mag, digit_cnt); else passed++;
    press(4'b0010, 4'd0);
    press(4'b0001, 4'd0);
    press(4'b0100, 4'd0);
    total++; if ({bus.the_output, bus.out_valid, bus.err} !== {8'h00, 1'b1, 1'b0})
      $display("FAIL edge_neg_zero: got out=%h v=%b e=%b, expected out=00 v=1 e=0", bus.the_output, bus.out_valid, bus.err); else passed++;
    @(negedge clk); bus.out_ack = 1'b1;
    @(negedge clk); bus.out_ack = 1'b0;
    press(4'b0001, 4'd6);
    press(4'b1100, 4'd6);
    total++; if ({bus.out_valid, bus.err, entry_mag, digit_cnt} !== {1'b0, 1'b0, 10'd0, 2'd0})
      $display("FAIL edge_clear_wins: got v=%b e=%b mag=%0d cnt=%0d, expected v=0 e=0 mag=0 cnt=0",
               bus.out_valid, bus.err, entry_mag, digit_cnt); else passed++;
  endtask

  task automatic test_async_reset;
    press(4'b0001, 4'd4);
    @(negedge clk); #2;
    reset = 1'b0;
    #1;
    total++; if ({bus.the_output, bus.out_valid, bus.err, entry_mag, entry_neg, digit_cnt} !== 23'd0)
      $display("FAIL async_mid_entry: got %h, expected 0", {bus.the_output, bus.out_valid, bus.err, entry_mag, entry_neg, digit_cnt});
    else passed++;
    @(negedge clk); reset = 1'b1;
    press(4'b0001, 4'd5);
    press(4'b0100, 4'd5);
    @(negedge clk); #2;
    reset = 1'b0;
    #1;
    total++; if ({bus.the_output, bus.out_valid, bus.err, entry_mag, entry_neg, digit_cnt} !== 23'd0)
      $display("FAIL async_mid_done: got %h, expected 0", {bus.the_output, bus.out_valid, bus.err, entry_mag, entry_neg, digit_cnt});
    else passed++;
    @(negedge clk); reset = 1'b1;
    press(4'b0001, 4'd3);
    total++; if ({entry_mag, digit_cnt, bus.out_valid} !== {10'd3, 2'd1, 1'b0})
      $display("FAIL async_restart: got mag=%0d cnt=%0d v=%b, expected mag=3 cnt=1 v=0", entry_mag, digit_cnt, bus.out_valid); else passed++;
  endtask

  initial begin
    test_reset();
    test_basic_entry();
    test_neg_range();
    test_bounce();
    test_handshake();
    test_edge_cases();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
